// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line transfers onto one physical-memory port.
// Define PMEM_ARB_ROUND_ROBIN_EN to alternate on contention; otherwise the D-cache always wins.
module pmem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D_RD, GRANT_D_WR, RELEASE} state_t;

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  logic [ADDR_W-1:0] line_mask;
  logic              i_req, d_req, contend_d, pick_d;

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_line_mask
      assign line_mask[gi] = (gi >= OFF_W);
    end
  endgenerate

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  assign contend_d = (last_grant_reg == SIDE_I);
`else
  assign contend_d = 1'b1;
`endif

  assign pick_d = d_req & (~i_req | contend_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= SIDE_I;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    i_pmem_resp     = 1'b0;
    d_pmem_resp     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_req | d_req) begin
          last_grant_next = pick_d ? SIDE_D : SIDE_I;
          if (pick_d) begin
            addr_next = d_pmem_address & line_mask;
            // A simultaneous read+write from the D-cache is resolved as the writeback.
            if (d_pmem_write) begin
              state_next = GRANT_D_WR;
              wdata_next = d_pmem_wdata;
            end else begin
              state_next = GRANT_D_RD;
            end
          end else begin
            addr_next  = i_pmem_address & line_mask;
            state_next = GRANT_I;
          end
        end
      end
      GRANT_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_pmem_resp = rst_n;
          state_next  = RELEASE;
        end
      end
      GRANT_D_RD: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          d_pmem_resp = rst_n;
          state_next  = RELEASE;
        end
      end
      GRANT_D_WR: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          d_pmem_resp = rst_n;
          state_next  = RELEASE;
        end
      end
      // One dead cycle so a requester still holding its strobe after resp is not re-served.
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign pmem_address = addr_reg;
  assign pmem_wdata   = wdata_reg;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed vector table, corner-case sequences,
// and randomized traffic checked against a transaction-level model.
module tb_pmem_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  always #5 clk = ~clk;

  pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic              i_rd;
    logic [ADDR_W-1:0] i_addr;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] wdata;
    logic [1:0]        exp_rw;    // {pmem_read, pmem_write}
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_i;     // 1 = I-cache granted
  } vec_t;

  vec_t vecs[7];

  int   n_cmp = 0, n_err = 0, cyc_n = 0, n_rise = 0, n_txn = 0;
  logic strobe_prev = 1'b0;
  bit   last_d_model;

  // random-phase model state
  int                free_at, last_resp, mem_cnt, i_st, d_mode;
  bit                active, d_pend, g_d, p_i, p_d, p_dw, exp_start;
  logic [1:0]        lat_rw, exp_rw;
  logic [ADDR_W-1:0] lat_addr, exp_addr, p_iaddr, p_daddr;
  logic [LINE_W-1:0] lat_wdata, p_wdata, rd_exp, rd;
  logic [ADDR_W-1:0] exp_ord[4];
  int                gap, w;

  task automatic go();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic look();
    @(negedge clk);
    if ((pmem_read | pmem_write) && !strobe_prev) n_rise++;
    strobe_prev = pmem_read | pmem_write;
  endtask

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~(ADDR_W'(LINE_W / 8) - 1);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit model_pick_d(input bit i, input bit d, input bit last_d);
    if (i && d) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return d;
  endfunction

  task automatic clear_inputs();
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
  endtask

  task automatic do_reset();
    go(); rst_n = 0; clear_inputs();
    go();
    go(); rst_n = 1;
    look();
    last_d_model = 0;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [LINE_W-1:0] r;
    go();
    pmem_resp = 0;
    i_pmem_read = v.i_rd; i_pmem_address = v.i_addr;
    d_pmem_read = v.d_rd; d_pmem_write = v.d_wr;
    d_pmem_address = v.d_addr; d_pmem_wdata = v.wdata;
    look();
    chk($sformatf("vec%0d_idle_strobe", k), {pmem_read, pmem_write}, 2'b00);
    go(); look();
    chk($sformatf("vec%0d_strobe", k), {pmem_read, pmem_write}, v.exp_rw);
    chk($sformatf("vec%0d_addr", k), pmem_address, v.exp_addr);
    if (v.exp_rw == 2'b01) chk($sformatf("vec%0d_wdata", k), pmem_wdata, v.wdata);
    // requester drops and scrambles its inputs mid-grant; the latched transfer must persist
    go();
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
    i_pmem_address = ~v.i_addr; d_pmem_address = ~v.d_addr; d_pmem_wdata = ~v.wdata;
    look();
    chk($sformatf("vec%0d_hold_strobe", k), {pmem_read, pmem_write}, v.exp_rw);
    chk($sformatf("vec%0d_hold_addr", k), pmem_address, v.exp_addr);
    if (v.exp_rw == 2'b01) chk($sformatf("vec%0d_hold_wdata", k), pmem_wdata, v.wdata);
    go(); r = rand_line(); pmem_rdata = r; pmem_resp = 1;
    look();
    chk($sformatf("vec%0d_resp", k), {i_pmem_resp, d_pmem_resp}, v.exp_i ? 2'b10 : 2'b01);
    chk($sformatf("vec%0d_rdata", k), v.exp_i ? i_pmem_rdata : d_pmem_rdata, r);
    chk($sformatf("vec%0d_resp_strobe", k), {pmem_read, pmem_write}, v.exp_rw);
    $display("txn vec%0d side=%s rw=%b addr=%h", k, v.exp_i ? "I" : "D", v.exp_rw, v.exp_addr);
    go(); pmem_rdata = ~r; pmem_resp = 1;  // stray resp during RELEASE
    look();
    chk($sformatf("vec%0d_release_strobe", k), {pmem_read, pmem_write}, 2'b00);
    chk($sformatf("vec%0d_release_resp", k), {i_pmem_resp, d_pmem_resp}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{i_rd:1, i_addr:32'h0000_1234, d_rd:0, d_wr:0, d_addr:32'h0, wdata:'0,
                exp_rw:2'b10, exp_addr:32'h0000_1220, exp_i:1};
    vecs[1] = '{i_rd:0, i_addr:32'h0, d_rd:0, d_wr:1, d_addr:32'h8000_00FF, wdata:{32{8'hA5}},
                exp_rw:2'b01, exp_addr:32'h8000_00E0, exp_i:0};
    vecs[2] = '{i_rd:0, i_addr:32'h0, d_rd:1, d_wr:0, d_addr:32'h0000_0040, wdata:'0,
                exp_rw:2'b10, exp_addr:32'h0000_0040, exp_i:0};
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    vecs[3] = '{i_rd:1, i_addr:32'h1111_111F, d_rd:1, d_wr:0, d_addr:32'h2222_2221, wdata:'0,
                exp_rw:2'b10, exp_addr:32'h1111_1100, exp_i:1};
`else
    vecs[3] = '{i_rd:1, i_addr:32'h1111_111F, d_rd:1, d_wr:0, d_addr:32'h2222_2221, wdata:'0,
                exp_rw:2'b10, exp_addr:32'h2222_2220, exp_i:0};
`endif
    vecs[4] = '{i_rd:1, i_addr:32'h3333_3333, d_rd:0, d_wr:1, d_addr:32'h4444_4444, wdata:{16{16'hC35A}},
                exp_rw:2'b01, exp_addr:32'h4444_4440, exp_i:0};
    vecs[5] = '{i_rd:0, i_addr:32'h0, d_rd:1, d_wr:1, d_addr:32'hFFFF_FFFF, wdata:{32{8'h5A}},
                exp_rw:2'b01, exp_addr:32'hFFFF_FFE0, exp_i:0};
    vecs[6] = '{i_rd:1, i_addr:32'hDEAD_BEEF, d_rd:0, d_wr:0, d_addr:32'h0, wdata:'0,
                exp_rw:2'b10, exp_addr:32'hDEAD_BEE0, exp_i:1};

    // reset held with a pending I request
    rst_n = 0; clear_inputs();
    i_pmem_read = 1; i_pmem_address = 32'h0000_1234;
    repeat (2) begin
      go(); look();
      chk("rst_strobes_resps", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, 4'b0);
      chk("rst_addr", pmem_address, 0);
      chk("rst_wdata", pmem_wdata, 0);
      chk("rst_rdata", {i_pmem_rdata, d_pmem_rdata}, 0);
    end
    go(); rst_n = 1; look();
    chk("rst_release_no_strobe", pmem_read, 1'b0);
    go(); look();
    chk("rst_first_strobe", pmem_read, 1'b1);
    go(); pmem_resp = 1; look();
    go(); pmem_resp = 0; i_pmem_read = 0; look();

    do_reset();
    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // continuous contention for four transactions
    do_reset();
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    exp_ord = '{32'h0000_2000, 32'h0000_1000, 32'h0000_2000, 32'h0000_1000};
`else
    exp_ord = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2000, 32'h0000_2000};
`endif
    go();
    i_pmem_read = 1; i_pmem_address = 32'h0000_1004;
    d_pmem_read = 1; d_pmem_address = 32'h0000_2008;
    look();
    gap = 0;
    for (int t = 0; t < 4; t++) begin
      while (!(pmem_read | pmem_write) && gap < 10) begin
        go(); pmem_resp = 0; look(); gap++;
      end
      if (t > 0) chk($sformatf("cont%0d_gap", t), gap, 3);
      chk($sformatf("cont%0d_order", t), pmem_address, exp_ord[t]);
      go(); pmem_resp = 1; pmem_rdata = rand_line(); look();
      chk($sformatf("cont%0d_resp", t), {i_pmem_resp, d_pmem_resp},
          (exp_ord[t] == 32'h0000_2000) ? 2'b01 : 2'b10);
      $display("txn cont%0d addr=%h", t, pmem_address);
      go(); pmem_resp = 0; look();
      gap = 1;
    end
    go(); i_pmem_read = 0; d_pmem_read = 0; look();

    // I-cache keeps its strobe one cycle past resp: must see exactly one fill
    do_reset();
    n_rise = 0;
    go(); i_pmem_read = 1; i_pmem_address = 32'h5000_0010; look();
    w = 0;
    do begin go(); look(); w++; end while (!pmem_read && w < 8);
    chk("hold_grant_latency", w, 1);
    go(); pmem_resp = 1; look();
    chk("hold_resp", {i_pmem_resp, d_pmem_resp}, 2'b10);
    go(); pmem_resp = 0; look();
    chk("hold_release", pmem_read, 1'b0);
    go(); i_pmem_read = 0; look();
    repeat (4) begin go(); look(); end
    chk("hold_single_fill", n_rise, 1);
    $display("txn hold addr=%h fills=%0d", pmem_address, n_rise);

    // reset during a D read grant, late resp afterwards
    do_reset();
    go(); d_pmem_read = 1; d_pmem_address = 32'h0000_6000; look();
    go(); look();
    chk("rstmid_granted", pmem_read, 1'b1);
    go(); rst_n = 0; look();
    chk("rstmid_no_resp", d_pmem_resp, 1'b0);
    go(); rst_n = 1; pmem_resp = 1; d_pmem_read = 0; look();
    chk("rstmid_strobe_drop", {pmem_read, pmem_write}, 2'b00);
    chk("rstmid_late_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    go(); pmem_resp = 0; d_pmem_read = 1; d_pmem_address = 32'h0000_7000; look();
    chk("rstmid_idle", pmem_read, 1'b0);
    go(); look();
    chk("rstmid_regrant", pmem_read, 1'b1);
    chk("rstmid_regrant_addr", pmem_address, 32'h0000_7000);
    go(); pmem_resp = 1; look();
    go(); pmem_resp = 0; d_pmem_read = 0; look();
    $display("txn rstmid regrant addr=%h", pmem_address);

    // randomized traffic against the transaction-level model
    do_reset();
    free_at = cyc_n; last_resp = -10; active = 0; mem_cnt = 0;
    i_st = 0; d_pend = 0; d_mode = 0;
    p_i = 0; p_d = 0; p_dw = 0; p_iaddr = '0; p_daddr = '0; p_wdata = '0;
    n_txn = 0;
    for (int k = 0; k < 2500; k++) begin
      go();
      pmem_resp = 0;
      if (active) begin
        if (mem_cnt == 0) begin
          pmem_resp = 1; rd_exp = rand_line(); pmem_rdata = rd_exp;
        end else mem_cnt--;
      end else if (cyc_n == last_resp + 1 && $urandom_range(0, 1) == 1) begin
        pmem_resp = 1; pmem_rdata = rand_line();
      end
      if (i_st == 0 && $urandom_range(0, 2) == 0) begin
        i_st = 1; i_pmem_address = $urandom;
      end
      i_pmem_read = (i_st != 0);
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_mode = $urandom_range(0, 7);
        d_pmem_address = $urandom; d_pmem_wdata = rand_line();
      end
      d_pmem_read  = d_pend && (d_mode < 4 || d_mode == 7);
      d_pmem_write = d_pend && (d_mode >= 4);
      look();

      if (!active) begin
        exp_start = (cyc_n - 1 >= free_at) && (p_i || p_d);
        chk("rnd_start", pmem_read | pmem_write, exp_start);
        chk("rnd_idle_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        if (pmem_read | pmem_write) begin
          g_d = model_pick_d(p_i, p_d, last_d_model);
          last_d_model = g_d;
          exp_rw   = (g_d && p_dw) ? 2'b01 : 2'b10;
          exp_addr = align(g_d ? p_daddr : p_iaddr);
          chk("rnd_rw", {pmem_read, pmem_write}, exp_rw);
          chk("rnd_addr", pmem_address, exp_addr);
          if (exp_rw == 2'b01) chk("rnd_wdata", pmem_wdata, p_wdata);
          active = 1; mem_cnt = $urandom_range(0, 3);
          lat_rw = exp_rw; lat_addr = exp_addr; lat_wdata = p_wdata;
        end
      end else begin
        chk("rnd_hold_rw", {pmem_read, pmem_write}, lat_rw);
        chk("rnd_hold_addr", pmem_address, lat_addr);
        if (lat_rw == 2'b01) chk("rnd_hold_wdata", pmem_wdata, lat_wdata);
        if (pmem_resp) begin
          chk("rnd_resp", {i_pmem_resp, d_pmem_resp}, g_d ? 2'b01 : 2'b10);
          chk("rnd_rdata", {i_pmem_rdata, d_pmem_rdata}, {rd_exp, rd_exp});
          n_txn++;
          $display("txn rnd%0d side=%s rw=%b addr=%h", n_txn, g_d ? "D" : "I", lat_rw, lat_addr);
          active = 0; free_at = cyc_n + 2; last_resp = cyc_n;
        end else begin
          chk("rnd_busy_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        end
      end

      if (i_st == 2) i_st = 0;
      else if (i_pmem_resp) i_st = 2;
      if (d_pmem_resp) d_pend = 0;
      p_i = i_pmem_read; p_d = d_pmem_read | d_pmem_write; p_dw = d_pmem_write;
      p_iaddr = i_pmem_address; p_daddr = d_pmem_address; p_wdata = d_pmem_wdata;
    end
    chk("rnd_progress", n_txn >= 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
